// File: rtl/mono_ctrl_pkg.sv
// Shared encodings for the monocycle run/step/halt sequencer.
package mono_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_RUN  = 2'b01,
    OP_STEP = 2'b10,
    OP_HALT = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

endpackage

// File: rtl/mono_exec_ctrl_if.sv
// Debug command port (valid/ready) into the monocycle execution controller.
interface mono_exec_ctrl_if #(
  parameter int STEP_W = 16
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/mono_exec_ctrl.sv
// Run/step/halt sequencer driving the single-cycle core's clock enable.
// Optional PC breakpoint logic is built only when MONO_BRKPT_EN is defined.
module mono_exec_ctrl
  import mono_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mono_exec_ctrl_if.slave      cmd,
  input  logic [31:0]          pc_in,
  input  logic                 brk_valid,
  input  logic [31:0]          brk_addr,
  output logic                 core_en,
  output logic                 halted,
  output logic                 brk_hit,
  output logic [CNT_W-1:0]     instr_cnt
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic [STEP_W-1:0] step_load;
  logic              accept;
  logic              leave_idle;
  logic              bp_match;

`ifdef MONO_BRKPT_EN
  logic skip_bp_q, skip_bp_d;
  logic brk_hit_q, brk_hit_d;

  assign bp_match = brk_valid && (pc_in == brk_addr) && !skip_bp_q;
  assign brk_hit  = brk_hit_q;

  // Resuming from a stop lets the instruction at brk_addr retire once.
  always_comb begin
    skip_bp_d = skip_bp_q;
    if (core_en)         skip_bp_d = 1'b0;
    else if (leave_idle) skip_bp_d = 1'b1;
    brk_hit_d = (state_d == ST_BREAK) && (state_q != ST_BREAK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_bp_q <= 1'b0;
      brk_hit_q <= 1'b0;
    end else begin
      skip_bp_q <= skip_bp_d;
      brk_hit_q <= brk_hit_d;
    end
  end
`else
  logic brk_unused;
  assign brk_unused = ^{brk_valid, brk_addr, pc_in, leave_idle};
  assign bp_match   = 1'b0;
  assign brk_hit    = 1'b0;
`endif

  assign step_load = (cmd.cmd_arg == '0) ? STEP_W'(1) : cmd.cmd_arg;

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    leave_idle  = 1'b0;
    cmd.cmd_ready = (state_q != ST_STEP);
    accept      = cmd.cmd_valid && cmd.cmd_ready;
    core_en     = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_match;
    instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, core_en};

    case (state_q)
      ST_HALT, ST_BREAK: begin
        if (accept && (cmd.cmd_op == OP_RUN)) begin
          state_d    = ST_RUN;
          leave_idle = 1'b1;
        end else if (accept && (cmd.cmd_op == OP_STEP)) begin
          state_d    = ST_STEP;
          step_cnt_d = step_load;
          leave_idle = 1'b1;
        end
      end
      ST_RUN: begin
        // A breakpoint outranks a HALT command landing in the same cycle.
        if (bp_match)                                state_d = ST_BREAK;
        else if (accept && (cmd.cmd_op == OP_HALT))  state_d = ST_HALT;
      end
      ST_STEP: begin
        if (bp_match) begin
          state_d    = ST_BREAK;
          step_cnt_d = '0;
        end else if (core_en) begin
          step_cnt_d = step_cnt_q - STEP_W'(1);
          if (step_cnt_q == STEP_W'(1)) state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      step_cnt_q  <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign halted    = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign instr_cnt = instr_cnt_q;

endmodule
